iob_pcie_chnl_host: RTL

- Core-side (host-side) end of the PCIe channel handshake: drives the CHNL_RX protocol into a user channel and consumes the CHNL_TX protocol from it.
- Counterpart of the user-side PCIe channel block. Lets the channel interface be used as the bus-facing master and, in simulation, loop a user channel back on itself.
- Two independent FSMs (RX issue, TX accept) on one clock domain.
- Descriptor/stream side uses valid/ready.

---
 rtl/iob_pcie_chnl_host.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/iob_pcie_chnl_host.sv
// iob_pcie_chnl_host: host-side end of the PCIe channel handshake.
// Issues CHNL_RX transactions and accepts CHNL_TX transactions.
module iob_pcie_chnl_host #(
  parameter int DATA_W           = 32,
  parameter int C_PCI_DATA_WIDTH = 64,
  parameter int ACK_TIMEOUT      = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_req_i,
  output logic                        rx_req_ready_o,
  input  logic [DATA_W-1:0]           rx_len_i,
  input  logic [DATA_W-2:0]           rx_off_i,
  input  logic                        rx_last_i,
  input  logic [C_PCI_DATA_WIDTH-1:0] src_data_i,
  input  logic                        src_valid_i,
  output logic                        src_ready_o,
  output logic                        rx_timeout_o,
  output logic                        CHNL_RX_o,
  output logic                        CHNL_RX_LAST_o,
  output logic [DATA_W-1:0]           CHNL_RX_LEN_o,
  output logic [DATA_W-2:0]           CHNL_RX_OFF_o,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA_o,
  output logic                        CHNL_RX_DATA_VALID_o,
  input  logic                        CHNL_RX_DATA_REN_i,
  input  logic                        CHNL_RX_ACK_i,
  input  logic                        CHNL_TX_i,
  input  logic                        CHNL_TX_LAST_i,
  input  logic [DATA_W-1:0]           CHNL_TX_LEN_i,
  input  logic [DATA_W-2:0]           CHNL_TX_OFF_i,
  input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA_i,
  input  logic                        CHNL_TX_DATA_VALID_i,
  output logic                        CHNL_TX_DATA_REN_o,
  output logic                        CHNL_TX_ACK_o,
  output logic [C_PCI_DATA_WIDTH-1:0] snk_data_o,
  output logic                        snk_valid_o,
  input  logic                        snk_ready_i,
  output logic [DATA_W-1:0]           tx_len_o,
  output logic                        tx_last_o,
  output logic                        tx_done_o,
  output logic                        tx_short_o
);

  localparam int TW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    RX_IDLE, RX_REQ, RX_DATA, RX_FIN
  } rx_st_e;

  typedef enum logic [1:0] {
    TX_IDLE, TX_ACK, TX_DATA, TX_DONE
  } tx_st_e;

  // Odd lengths round up; the extra bit keeps all-ones from wrapping.
  function automatic logic [DATA_W-1:0] nwords(
    input logic [DATA_W-1:0] len
  );
    logic [DATA_W:0] s;
    s = {1'b0, len} + {{DATA_W{1'b0}}, 1'b1};
    return s[DATA_W:1];
  endfunction

  rx_st_e              rx_st_q, rx_st_d;
  logic [DATA_W-1:0]   rx_len_q, rx_len_d;
  logic [DATA_W-2:0]   rx_off_q, rx_off_d;
  logic                rx_last_q, rx_last_d;
  logic [DATA_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [TW-1:0]       rx_tmo_q, rx_tmo_d;

  tx_st_e              tx_st_q, tx_st_d;
  logic [DATA_W-1:0]   tx_len_q, tx_len_d;
  logic                tx_last_q, tx_last_d;
  logic [DATA_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic                tx_done_q, tx_done_d;
  logic                tx_short_q, tx_short_d;

  logic                tx_off_unused;

  assign tx_off_unused = ^CHNL_TX_OFF_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_st_q    <= RX_IDLE;
      rx_len_q   <= '0;
      rx_off_q   <= '0;
      rx_last_q  <= 1'b0;
      rx_cnt_q   <= '0;
      rx_tmo_q   <= '0;
      tx_st_q    <= TX_IDLE;
      tx_len_q   <= '0;
      tx_last_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_done_q  <= 1'b0;
      tx_short_q <= 1'b0;
    end else begin
      rx_st_q    <= rx_st_d;
      rx_len_q   <= rx_len_d;
      rx_off_q   <= rx_off_d;
      rx_last_q  <= rx_last_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_tmo_q   <= rx_tmo_d;
      tx_st_q    <= tx_st_d;
      tx_len_q   <= tx_len_d;
      tx_last_q  <= tx_last_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_done_q  <= tx_done_d;
      tx_short_q <= tx_short_d;
    end
  end

  always_comb begin
    rx_st_d              = rx_st_q;
    rx_len_d             = rx_len_q;
    rx_off_d             = rx_off_q;
    rx_last_d            = rx_last_q;
    rx_cnt_d             = rx_cnt_q;
    rx_tmo_d             = '0;
    rx_req_ready_o       = 1'b0;
    rx_timeout_o         = 1'b0;
    CHNL_RX_o            = 1'b0;
    CHNL_RX_DATA_o       = '0;
    CHNL_RX_DATA_VALID_o = 1'b0;
    src_ready_o          = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        rx_req_ready_o = rst;
        if (rx_req_i) begin
          rx_len_d  = rx_len_i;
          rx_off_d  = rx_off_i;
          rx_last_d = rx_last_i;
          rx_cnt_d  = nwords(rx_len_i);
          rx_st_d   = RX_REQ;
        end
      end
      RX_REQ: begin
        CHNL_RX_o = 1'b1;
        rx_tmo_d  = rx_tmo_q + TW'(1);
        if (CHNL_RX_ACK_i) begin
          rx_st_d = (rx_cnt_q == '0) ? RX_FIN : RX_DATA;
        end else if (rx_tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          rx_timeout_o = 1'b1;
          rx_st_d      = RX_FIN;
        end
      end
      RX_DATA: begin
        CHNL_RX_o            = 1'b1;
        CHNL_RX_DATA_VALID_o = src_valid_i;
        CHNL_RX_DATA_o       = src_data_i;
        src_ready_o          = CHNL_RX_DATA_REN_i;
        if (src_valid_i && CHNL_RX_DATA_REN_i) begin
          rx_cnt_d = rx_cnt_q - DATA_W'(1);
          if (rx_cnt_q == DATA_W'(1)) rx_st_d = RX_FIN;
        end
      end
      RX_FIN:  rx_st_d = RX_IDLE;
      default: rx_st_d = RX_IDLE;
    endcase
  end

  assign CHNL_RX_LEN_o  = rx_len_q;
  assign CHNL_RX_OFF_o  = rx_off_q;
  assign CHNL_RX_LAST_o = rx_last_q;

  always_comb begin
    tx_st_d            = tx_st_q;
    tx_len_d           = tx_len_q;
    tx_last_d          = tx_last_q;
    tx_cnt_d           = tx_cnt_q;
    tx_short_d         = 1'b0;
    CHNL_TX_ACK_o      = 1'b0;
    CHNL_TX_DATA_REN_o = 1'b0;
    snk_valid_o        = 1'b0;
    snk_data_o         = '0;
    unique case (tx_st_q)
      TX_IDLE: begin
        if (CHNL_TX_i) begin
          tx_len_d  = CHNL_TX_LEN_i;
          tx_last_d = CHNL_TX_LAST_i;
          tx_cnt_d  = nwords(CHNL_TX_LEN_i);
          tx_st_d   = TX_ACK;
        end
      end
      TX_ACK: begin
        CHNL_TX_ACK_o = 1'b1;
        tx_st_d = (tx_cnt_q == '0) ? TX_DONE : TX_DATA;
      end
      TX_DATA: begin
        CHNL_TX_DATA_REN_o = snk_ready_i;
        snk_valid_o        = CHNL_TX_DATA_VALID_i;
        snk_data_o         = CHNL_TX_DATA_i;
        if (CHNL_TX_DATA_VALID_i && snk_ready_i) begin
          tx_cnt_d = tx_cnt_q - DATA_W'(1);
        end
        if (tx_cnt_d == '0) begin
          tx_st_d = TX_DONE;
        end else if (!CHNL_TX_i) begin
          tx_st_d    = TX_DONE;
          tx_short_d = 1'b1;
        end
      end
      TX_DONE: begin
        if (!CHNL_TX_i) tx_st_d = TX_IDLE;
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  // Done pulses only on the cycle DONE is first entered.
  assign tx_done_d  = (tx_st_d == TX_DONE) && (tx_st_q != TX_DONE);
  assign tx_done_o  = tx_done_q;
  assign tx_short_o = tx_short_q;
  assign tx_len_o   = tx_len_q;
  assign tx_last_o  = tx_last_q;

endmodule
